ahb_master_mux: RTL and testbench



---
 rtl/ahb_master_mux.sv | 95 +++++++++
 tb/tb_ahb_master_mux.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_mux.sv
// AHB master-side multiplexer: registers the address-phase owner from the arbiter
// grant, pipelines it into the data phase and steers the shared bus from both owners.
module ahb_master_mux #(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                          HCLK,
    input  logic                          rst_n,
    input  logic [NUM_MASTERS-1:0]        HGRANT_i,
    input  logic                          HREADY_i,
    input  logic [ADDR_W*NUM_MASTERS-1:0] HADDR_m,
    input  logic [2*NUM_MASTERS-1:0]      HTRANS_m,
    input  logic [NUM_MASTERS-1:0]        HWRITE_m,
    input  logic [3*NUM_MASTERS-1:0]      HSIZE_m,
    input  logic [3*NUM_MASTERS-1:0]      HBURST_m,
    input  logic [NUM_MASTERS-1:0]        HLOCK_m,
    input  logic [DATA_W*NUM_MASTERS-1:0] HWDATA_m,
    output logic [ADDR_W-1:0]             HADDR_o,
    output logic [1:0]                    HTRANS_o,
    output logic                          HWRITE_o,
    output logic [2:0]                    HSIZE_o,
    output logic [2:0]                    HBURST_o,
    output logic [DATA_W-1:0]             HWDATA_o,
    output logic [3:0]                    HMASTER_o,
    output logic                          HMASTLOCK_o,
    output logic [3:0]                    HMASTER_DATA_o,
    output logic                          data_valid_o,
    output logic                          handover_o
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [IDX_W-1:0] DEF_IDX = IDX_W'(DEFAULT_MASTER);

    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] addr_owner;
    logic [IDX_W-1:0] data_owner;
    logic             data_valid;
    logic             handover;

    logic [ADDR_W-1:0] haddr_arr  [NUM_MASTERS];
    logic [1:0]        htrans_arr [NUM_MASTERS];
    logic [2:0]        hsize_arr  [NUM_MASTERS];
    logic [2:0]        hburst_arr [NUM_MASTERS];
    logic [DATA_W-1:0] hwdata_arr [NUM_MASTERS];

    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
        assign haddr_arr[k]  = HADDR_m[k*ADDR_W +: ADDR_W];
        assign htrans_arr[k] = HTRANS_m[k*2 +: 2];
        assign hsize_arr[k]  = HSIZE_m[k*3 +: 3];
        assign hburst_arr[k] = HBURST_m[k*3 +: 3];
        assign hwdata_arr[k] = HWDATA_m[k*DATA_W +: DATA_W];
    end

    // Descending scan so the lowest set grant bit is the last (winning) assignment.
    always_comb begin
        grant_idx = DEF_IDX;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (HGRANT_i[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge HCLK or negedge rst_n) begin
        if (!rst_n) begin
            addr_owner <= DEF_IDX;
            data_owner <= DEF_IDX;
            data_valid <= 1'b0;
            handover   <= 1'b0;
        end else if (HREADY_i) begin
            addr_owner <= grant_idx;
            data_owner <= addr_owner;
            data_valid <= HTRANS_o[1];
            handover   <= (grant_idx != addr_owner);
        end else begin
            handover   <= 1'b0;
        end
    end

    // HTRANS is gated by reset so slaves see IDLE the moment reset asserts.
    assign HADDR_o        = haddr_arr[addr_owner];
    assign HTRANS_o       = rst_n ? htrans_arr[addr_owner] : 2'b00;
    assign HWRITE_o       = HWRITE_m[addr_owner];
    assign HSIZE_o        = hsize_arr[addr_owner];
    assign HBURST_o       = hburst_arr[addr_owner];
    assign HMASTLOCK_o    = HLOCK_m[addr_owner];
    assign HWDATA_o       = hwdata_arr[data_owner];
    assign HMASTER_o      = 4'(addr_owner);
    assign HMASTER_DATA_o = 4'(data_owner);
    assign data_valid_o   = data_valid;
    assign handover_o     = handover;

endmodule

// File: tb/tb_ahb_master_mux.sv
// Directed bench for ahb_master_mux: reset, handover, wait states, write data,
// multi-hot grant and asynchronous reset mid-burst.
module tb_ahb_master_mux;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic           HCLK;
    logic           rst_n;
    logic [NM-1:0]  HGRANT_i;
    logic           HREADY_i;
    logic [AW*NM-1:0] HADDR_m;
    logic [2*NM-1:0]  HTRANS_m;
    logic [NM-1:0]    HWRITE_m;
    logic [3*NM-1:0]  HSIZE_m;
    logic [3*NM-1:0]  HBURST_m;
    logic [NM-1:0]    HLOCK_m;
    logic [DW*NM-1:0] HWDATA_m;
    logic [AW-1:0]  HADDR_o;
    logic [1:0]     HTRANS_o;
    logic           HWRITE_o;
    logic [2:0]     HSIZE_o;
    logic [2:0]     HBURST_o;
    logic [DW-1:0]  HWDATA_o;
    logic [3:0]     HMASTER_o;
    logic           HMASTLOCK_o;
    logic [3:0]     HMASTER_DATA_o;
    logic           data_valid_o;
    logic           handover_o;

    logic [AW-1:0] m_addr  [NM];
    logic [1:0]    m_trans [NM];
    logic          m_write [NM];
    logic [2:0]    m_size  [NM];
    logic [2:0]    m_burst [NM];
    logic          m_lock  [NM];
    logic [DW-1:0] m_wdata [NM];

    int total = 0;
    int bad   = 0;

    for (genvar k = 0; k < NM; k++) begin : g_pack
        assign HADDR_m[k*AW +: AW] = m_addr[k];
        assign HTRANS_m[k*2 +: 2]  = m_trans[k];
        assign HWRITE_m[k]         = m_write[k];
        assign HSIZE_m[k*3 +: 3]   = m_size[k];
        assign HBURST_m[k*3 +: 3]  = m_burst[k];
        assign HLOCK_m[k]          = m_lock[k];
        assign HWDATA_m[k*DW +: DW] = m_wdata[k];
    end

    ahb_master_mux #(
        .NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .DEFAULT_MASTER(0)
    ) dut (
        .HCLK(HCLK), .rst_n(rst_n), .HGRANT_i(HGRANT_i), .HREADY_i(HREADY_i),
        .HADDR_m(HADDR_m), .HTRANS_m(HTRANS_m), .HWRITE_m(HWRITE_m),
        .HSIZE_m(HSIZE_m), .HBURST_m(HBURST_m), .HLOCK_m(HLOCK_m),
        .HWDATA_m(HWDATA_m), .HADDR_o(HADDR_o), .HTRANS_o(HTRANS_o),
        .HWRITE_o(HWRITE_o), .HSIZE_o(HSIZE_o), .HBURST_o(HBURST_o),
        .HWDATA_o(HWDATA_o), .HMASTER_o(HMASTER_o), .HMASTLOCK_o(HMASTLOCK_o),
        .HMASTER_DATA_o(HMASTER_DATA_o), .data_valid_o(data_valid_o),
        .handover_o(handover_o)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        HREADY_i = 1'b1;
        HGRANT_i = 4'b0001;
        for (int k = 0; k < NM; k++) begin
            m_addr[k]  = 32'h1000 * (k + 1);
            m_trans[k] = 2'b10;
            m_write[k] = 1'b0;
            m_size[k]  = 3'(k);
            m_burst[k] = 3'(k + 1);
            m_lock[k]  = 1'b0;
            m_wdata[k] = 32'hA000_0000 + k;
        end
        m_wdata[3] = 32'hDEAD_BEEF;

        // Reset held with all masters NONSEQ
        step();
        step();
        check_val("rst_htrans",    HTRANS_o, 2'b00);
        check_val("rst_hmaster",   HMASTER_o, 4'd0);
        check_val("rst_hmaster_d", HMASTER_DATA_o, 4'd0);
        check_val("rst_dvalid",    data_valid_o, 1'b0);
        check_val("rst_handover",  handover_o, 1'b0);

        rst_n    = 1'b1;
        HGRANT_i = 4'b0000;
        step();
        check_val("nogrant_hmaster",  HMASTER_o, 4'd0);
        check_val("nogrant_handover", handover_o, 1'b0);
        check_val("nogrant_dvalid",   data_valid_o, 1'b1);

        // Overlapped handover 0 -> 2
        HGRANT_i = 4'b0001;
        step();
        check_val("m0_haddr", HADDR_o, 32'h1000);
        HGRANT_i = 4'b0100;
        step();
        check_val("ho_haddr",     HADDR_o, 32'h3000);
        check_val("ho_hmaster",   HMASTER_o, 4'd2);
        check_val("ho_hmaster_d", HMASTER_DATA_o, 4'd0);
        check_val("ho_dvalid",    data_valid_o, 1'b1);
        check_val("ho_handover",  handover_o, 1'b1);
        step();
        check_val("ho_handover_clr", handover_o, 1'b0);
        check_val("ho_hmaster_d2",   HMASTER_DATA_o, 4'd2);

        // Wait states: grant to 1 ignored while HREADY low
        HGRANT_i = 4'b0010;
        HREADY_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("ws_hmaster_%0d", i), HMASTER_o, 4'd2);
            check_val($sformatf("ws_handover_%0d", i), handover_o, 1'b0);
        end
        HREADY_i = 1'b1;
        step();
        check_val("ws_release_hmaster",  HMASTER_o, 4'd1);
        check_val("ws_release_handover", handover_o, 1'b1);
        check_val("ws_release_hmaster_d", HMASTER_DATA_o, 4'd2);

        // Write by master 3
        m_write[3] = 1'b1;
        HGRANT_i   = 4'b1000;
        step();
        check_val("wr_hmaster", HMASTER_o, 4'd3);
        check_val("wr_hwrite",  HWRITE_o, 1'b1);
        check_val("wr_htrans",  HTRANS_o, 2'b10);
        check_val("wr_hwdata_prev", HWDATA_o, 32'hA000_0001);
        HREADY_i = 1'b0;
        step();
        check_val("wr_ws_hmaster_d", HMASTER_DATA_o, 4'd1);
        HREADY_i = 1'b1;
        step();
        check_val("wr_hmaster_d", HMASTER_DATA_o, 4'd3);
        check_val("wr_hwdata",    HWDATA_o, 32'hDEAD_BEEF);
        check_val("wr_dvalid",    data_valid_o, 1'b1);
        m_write[3] = 1'b0;

        // Multi-hot grant: lowest index wins
        m_lock[1] = 1'b1;
        HGRANT_i  = 4'b1010;
        step();
        check_val("mh_hmaster", HMASTER_o, 4'd1);
        check_val("mh_lock",    HMASTLOCK_o, 1'b1);
        check_val("mh_hsize",   HSIZE_o, 3'd1);
        check_val("mh_hburst",  HBURST_o, 3'd2);
        check_val("mh_haddr",   HADDR_o, 32'h2000);
        m_lock[1] = 1'b0;
        #1;
        check_val("mh_lock_drop", HMASTLOCK_o, 1'b0);

        // No grant falls back to default; IDLE gives data_valid=0
        HGRANT_i   = 4'b0000;
        m_trans[0] = 2'b00;
        step();
        check_val("def_hmaster", HMASTER_o, 4'd0);
        check_val("def_htrans",  HTRANS_o, 2'b00);
        step();
        check_val("idle_dvalid", data_valid_o, 1'b0);
        check_val("idle_hmaster_d", HMASTER_DATA_o, 4'd0);

        // Async reset during a SEQ burst by master 2
        HGRANT_i   = 4'b0100;
        m_trans[2] = 2'b11;
        step();
        step();
        check_val("burst_htrans",    HTRANS_o, 2'b11);
        check_val("burst_hmaster_d", HMASTER_DATA_o, 4'd2);
        check_val("burst_dvalid",    data_valid_o, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("arst_htrans",    HTRANS_o, 2'b00);
        check_val("arst_hmaster",   HMASTER_o, 4'd0);
        check_val("arst_hmaster_d", HMASTER_DATA_o, 4'd0);
        check_val("arst_dvalid",    data_valid_o, 1'b0);
        check_val("arst_handover",  handover_o, 1'b0);
        check_val("arst_hwdata",    HWDATA_o, 32'hA000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
